// File: rtl/enc_link_arbiter_if.sv
// Requester lanes and encoder-side symbol port of the link arbiter.
// The slave modport is the arbiter's view; master is the requesters/encoder side.
interface enc_link_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              enc_ready;
  logic              enc_push;
  logic [8:0]        enc_data;
  logic              enc_start;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              trunc;

  modport master (
    output req_valid, req_data, req_last, enc_ready,
    input  req_ready, enc_push, enc_data, enc_start, grant_id, busy, trunc
  );

  modport slave (
    input  req_valid, req_data, req_last, enc_ready,
    output req_ready, enc_push, enc_data, enc_start, grant_id, busy, trunc
  );
endinterface

// File: rtl/enc_link_arbiter.sv
// Round-robin packet arbiter in front of the 8b/10b encoder: per grant it sends a
// four-symbol K28.1 preamble, the payload bytes, then idles for the encoder trailer.
module enc_link_arbiter #(
  parameter int NREQ   = 4,
  parameter int MAXLEN = 64,
  parameter int GAP    = 6
) (
  input logic             clk,
  input logic             reset,
  enc_link_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int IW1 = IDW + 1;
  localparam int BW  = $clog2(MAXLEN + 1);
  localparam logic [8:0] K28_1 = 9'h13C;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [1:0]      pcnt_q, pcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic            enc_push_q, enc_push_d;
  logic            enc_start_q, enc_start_d;
  logic [8:0]      enc_data_q, enc_data_d;
  logic            busy_q, busy_d;
  logic            trunc_q, trunc_d;

  logic [IDW-1:0]  pick;
  logic            found;
  logic [IW1-1:0]  cand;
  logic [IW1-1:0]  g_inc;
  logic [BW-1:0]   bcnt_inc;
  logic [NREQ-1:0] req_ready;
  logic            xfer;
  logic            last_byte;
  logic            at_max;

  // Scan offsets from high to low so the smallest offset from rr is what remains.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + IW1'(k);
      if (cand >= IW1'(NREQ)) begin
        cand = cand - IW1'(NREQ);
      end
      if (bus.req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_DATA && bus.enc_ready) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  assign xfer      = bus.req_valid[grant_id_q] & req_ready[grant_id_q];
  assign last_byte = bus.req_last[grant_id_q];
  assign bcnt_inc  = bcnt_q + 1'b1;
  assign at_max    = (bcnt_inc == BW'(MAXLEN));
  assign g_inc     = {1'b0, grant_id_q} + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_id_d  = grant_id_q;
    pcnt_d      = pcnt_q;
    bcnt_d      = bcnt_q;
    gcnt_d      = gcnt_q;
    enc_push_d  = 1'b0;
    enc_start_d = 1'b0;
    enc_data_d  = '0;
    trunc_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_id_d = pick;
          pcnt_d     = '0;
          bcnt_d     = '0;
          state_d    = S_PRE;
        end
      end
      S_PRE: begin
        if (bus.enc_ready) begin
          enc_push_d  = 1'b1;
          enc_data_d  = K28_1;
          enc_start_d = (pcnt_q == 2'd0);
          pcnt_d      = pcnt_q + 2'd1;
          if (pcnt_q == 2'd3) begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          enc_push_d = 1'b1;
          enc_data_d = {1'b0, bus.req_data[8*grant_id_q +: 8]};
          bcnt_d     = bcnt_inc;
          // A cut packet leaves the rest of the lane's bytes for a later grant.
          if (last_byte || at_max) begin
            trunc_d = ~last_byte;
            rr_d    = (g_inc == IW1'(NREQ)) ? '0 : g_inc[IDW-1:0];
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gcnt_q == 4'(GAP - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_id_q  <= '0;
      pcnt_q      <= '0;
      bcnt_q      <= '0;
      gcnt_q      <= '0;
      enc_push_q  <= 1'b0;
      enc_start_q <= 1'b0;
      enc_data_q  <= '0;
      busy_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_id_q  <= grant_id_d;
      pcnt_q      <= pcnt_d;
      bcnt_q      <= bcnt_d;
      gcnt_q      <= gcnt_d;
      enc_push_q  <= enc_push_d;
      enc_start_q <= enc_start_d;
      enc_data_q  <= enc_data_d;
      busy_q      <= busy_d;
      trunc_q     <= trunc_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.enc_push  = enc_push_q;
  assign bus.enc_data  = enc_data_q;
  assign bus.enc_start = enc_start_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
  assign bus.trunc     = trunc_q;
endmodule
